vga_edit_controller: RTL and testbench

- Sequences the clock-programming mode of the VGA display.
- Owns the edit cursor (direccion_actual_pantalla) and programar_on consumed by the hour/date/timer renderers, and the cursor blink timing.
- Owns an edit buffer for the selected field, adjusted in BCD by buttons.
- Commits edited values to the RTC register side through a req/ack write handshake. Sits between the debounced button logic, the VGA sync generator and the RTC bank.

---
 rtl/vga_edit_controller.sv | 187 ++++++++++++++++++
 tb/tb_vga_edit_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_edit_controller.sv
// Clock-programming sequencer for the VGA display: edit cursor, BCD edit buffer,
// cursor blink and req/ack commit of edited fields to the RTC bank.
module vga_edit_controller #(
  parameter int FRAME_BLINK = 30,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       frame_start,
  input  logic       alarm_active,
  input  logic [7:0] cur_value,
  input  logic       wr_ack,
  output logic       programar_on,
  output logic [3:0] direccion_actual_pantalla,
  output logic       cursor_visible,
  output logic [7:0] edit_value,
  output logic       wr_req,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_error
);

  localparam int BW = (FRAME_BLINK > 1) ? $clog2(FRAME_BLINK) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(FRAME_BLINK - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EDIT, S_WRITE, S_WAIT} state_t;
  typedef enum logic [1:0] {A_RIGHT, A_LEFT, A_PROG} act_t;

  state_t          r_state;
  act_t            r_pend;
  logic            r_dirty;
  logic            r_alarm_seen;
  logic [BW-1:0]   r_blink;
  logic [TW-1:0]   r_to_cnt;

  logic [7:0] w_min, w_max, w_inc, w_dec, w_load;
  logic [3:0] w_dir_right, w_dir_left;
  logic       w_nav, w_exec;
  act_t       w_btn_act, w_exec_act;

  // Field ranges and BCD step/clamp for the currently selected field
  always_comb begin
    w_min = 8'h00;
    w_max = 8'h59;
    case (direccion_actual_pantalla)
      4'd0, 4'd6: w_max = 8'h23;
      4'd3: begin w_min = 8'h01; w_max = 8'h31; end
      4'd4: begin w_min = 8'h01; w_max = 8'h12; end
      4'd5: w_max = 8'h99;
      default: ;
    endcase
    if (edit_value == w_max)           w_inc = w_min;
    else if (edit_value[3:0] >= 4'd9)  w_inc = {edit_value[7:4] + 4'd1, 4'h0};
    else                               w_inc = edit_value + 8'd1;
    if (edit_value == w_min)           w_dec = w_max;
    else if (edit_value[3:0] == 4'd0)  w_dec = {edit_value[7:4] - 4'd1, 4'h9};
    else                               w_dec = edit_value - 8'd1;
    if (cur_value[7:4] > 4'd9 || cur_value[3:0] > 4'd9 ||
        cur_value < w_min || cur_value > w_max) w_load = w_min;
    else                                        w_load = cur_value;
    w_dir_right = (direccion_actual_pantalla >= 4'd8) ? 4'd0 : direccion_actual_pantalla + 4'd1;
    w_dir_left  = (direccion_actual_pantalla == 4'd0) ? 4'd8 : direccion_actual_pantalla - 4'd1;
  end

  // Navigation decode plus the action to run this cycle; an abort behaves like prog (exit to IDLE)
  always_comb begin
    w_nav      = 1'b1;
    w_btn_act  = A_PROG;
    if (btn_prog)       w_btn_act = A_PROG;
    else if (btn_right) w_btn_act = A_RIGHT;
    else if (btn_left)  w_btn_act = A_LEFT;
    else                w_nav     = 1'b0;
    w_exec     = 1'b0;
    w_exec_act = A_PROG;
    case (r_state)
      S_EDIT: begin
        if (alarm_active) begin
          w_exec = 1'b1;
        end else if (w_nav && !r_dirty) begin
          w_exec     = 1'b1;
          w_exec_act = w_btn_act;
        end
      end
      S_WAIT: begin
        if (wr_ack || r_to_cnt == TO_LAST) begin
          w_exec     = 1'b1;
          w_exec_act = (alarm_active || r_alarm_seen) ? A_PROG : r_pend;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                   <= S_IDLE;
      r_pend                    <= A_PROG;
      r_dirty                   <= 1'b0;
      r_alarm_seen              <= 1'b0;
      r_blink                   <= '0;
      r_to_cnt                  <= '0;
      programar_on              <= 1'b0;
      direccion_actual_pantalla <= 4'd15;
      cursor_visible            <= 1'b0;
      edit_value                <= 8'h00;
      wr_req                    <= 1'b0;
      wr_addr                   <= 4'd0;
      wr_data                   <= 8'h00;
      wr_error                  <= 1'b0;
    end else begin
      wr_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (btn_prog && !alarm_active) begin
            r_state                   <= S_LOAD;
            direccion_actual_pantalla <= 4'd0;
            programar_on              <= 1'b1;
          end
        end
        S_LOAD: begin
          edit_value     <= w_load;
          r_dirty        <= 1'b0;
          r_blink        <= '0;
          cursor_visible <= 1'b1;
          r_state        <= S_EDIT;
        end
        S_EDIT: begin
          if (!alarm_active && w_nav && r_dirty) begin
            r_pend  <= w_btn_act;
            r_state <= S_WRITE;
          end else if (!alarm_active && !w_nav && (btn_up || btn_down)) begin
            edit_value     <= btn_up ? w_inc : w_dec;
            r_dirty        <= 1'b1;
            r_blink        <= '0;
            cursor_visible <= 1'b1;
          end else if (!w_exec && frame_start) begin
            if (r_blink == BLINK_LAST) begin
              r_blink        <= '0;
              cursor_visible <= ~cursor_visible;
            end else begin
              r_blink <= r_blink + 1'b1;
            end
          end
        end
        S_WRITE: begin
          wr_addr      <= direccion_actual_pantalla;
          wr_data      <= edit_value;
          wr_req       <= 1'b1;
          r_to_cnt     <= '0;
          r_alarm_seen <= alarm_active;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (alarm_active) r_alarm_seen <= 1'b1;
          if (w_exec) begin
            wr_req   <= 1'b0;
            wr_error <= ~wr_ack;
            r_dirty  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_exec) begin
        case (w_exec_act)
          A_RIGHT: begin direccion_actual_pantalla <= w_dir_right; r_state <= S_LOAD; end
          A_LEFT:  begin direccion_actual_pantalla <= w_dir_left;  r_state <= S_LOAD; end
          default: begin
            r_state                   <= S_IDLE;
            programar_on              <= 1'b0;
            direccion_actual_pantalla <= 4'd15;
            cursor_visible            <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_edit_controller.sv
// Scoreboard bench: stimulus queues expected snapshots and writes, a negedge monitor compares.
module tb_vga_edit_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_prog, btn_left, btn_right, btn_up, btn_down, frame_start;
  logic       alarm_active;
  logic [7:0] cur_value;
  logic       wr_ack;
  logic       programar_on;
  logic [3:0] direccion_actual_pantalla;
  logic       cursor_visible;
  logic [7:0] edit_value;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_error;

  vga_edit_controller #(.FRAME_BLINK(2), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .btn_prog(btn_prog), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .frame_start(frame_start),
    .alarm_active(alarm_active), .cur_value(cur_value), .wr_ack(wr_ack),
    .programar_on(programar_on), .direccion_actual_pantalla(direccion_actual_pantalla),
    .cursor_visible(cursor_visible), .edit_value(edit_value),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_error(wr_error)
  );

  always #5 clk = ~clk;

  // RTC field contents seen through cur_value
  logic [7:0] fld [0:15];
  always_comb cur_value = fld[direccion_actual_pantalla];

  typedef struct { string name; int prog, dir, vis, ev, req, err; } exp_t;
  typedef struct { int addr, data; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_req = 1'b0;

  localparam logic [5:0] B_PROG = 6'b100000, B_RIGHT = 6'b010000, B_LEFT = 6'b001000,
                         B_UP   = 6'b000100, B_DOWN  = 6'b000010, B_FRAME = 6'b000001;

  task automatic chk(input string nm, input int act, input int req);
    if (req < 0) return;
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".prog"}, int'(programar_on), e.prog);
      chk({e.name, ".dir"},  int'(direccion_actual_pantalla), e.dir);
      chk({e.name, ".vis"},  int'(cursor_visible), e.vis);
      chk({e.name, ".edit"}, int'(edit_value), e.ev);
      chk({e.name, ".req"},  int'(wr_req), e.req);
      chk({e.name, ".err"},  int'(wr_error), e.err);
    end
    if (wr_req && !prev_req) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: actual addr=%0d data=%02h required none", wr_addr, wr_data);
      end else begin
        w = wr_q.pop_front();
        chk("write.addr", int'(wr_addr), w.addr);
        chk("write.data", int'(wr_data), w.data);
      end
    end
    prev_req <= wr_req;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [5:0] b);
    {btn_prog, btn_right, btn_left, btn_up, btn_down, frame_start} = b;
    step(1);
    {btn_prog, btn_right, btn_left, btn_up, btn_down, frame_start} = 6'b0;
  endtask

  task automatic expect_st(input string nm, input int p, input int d, input int v,
                           input int e, input int rq, input int er);
    exp_t x;
    x.name = nm; x.prog = p; x.dir = d; x.vis = v; x.ev = e; x.req = rq; x.err = er;
    exp_q.push_back(x);
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic ack;
    wr_ack = 1'b1;
    step(1);
    wr_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) fld[i] = 8'h00;
    fld[0] = 8'h23; fld[1] = 8'h45; fld[2] = 8'h30; fld[3] = 8'h09; fld[4] = 8'h01;
    fld[5] = 8'h99; fld[6] = 8'h12; fld[7] = 8'h00; fld[8] = 8'h59;
    reset = 1'b1; alarm_active = 1'b0; wr_ack = 1'b0;
    {btn_prog, btn_right, btn_left, btn_up, btn_down, frame_start} = 6'b0;
    step(2);
    expect_st("reset", 0, 15, 0, 0, 0, 0);
    reset = 1'b0;
    pulse(B_UP);   expect_st("idle_ignore", 0, 15, 0, 0, 0, 0);

    // enter, edit hour 23 -> 00, commit by moving right
    pulse(B_PROG); expect_st("enter", 1, 0, 0, 0, 0, 0);
    step();        expect_st("load0", 1, 0, 1, 'h23, 0, 0);
    pulse(B_UP);   expect_st("hour_up_wrap", 1, 0, 1, 'h00, 0, 0);
    push_wr(0, 'h00);
    pulse(B_RIGHT); expect_st("write_state", 1, 0, -1, 'h00, 0, 0);
    step();         expect_st("req_up", 1, 0, -1, 'h00, 1, 0);
    step(2);        expect_st("req_hold", 1, 0, -1, -1, 1, 0);
    ack();          expect_st("ack_drop", 1, 1, -1, -1, 0, 0);
    step();         expect_st("load1", 1, 1, 1, 'h45, 0, 0);

    // cursor wrap without dirty data
    pulse(B_LEFT);  expect_st("left", 1, 0, -1, -1, 0, 0);
    step();
    pulse(B_LEFT);  expect_st("left_wrap", 1, 8, -1, -1, 0, 0);
    step();         expect_st("load8", 1, 8, 1, 'h59, 0, 0);
    pulse(B_RIGHT); expect_st("right_wrap", 1, 0, -1, -1, 0, 0);
    step();
    repeat (4) begin pulse(B_RIGHT); step(); end
    expect_st("load4", 1, 4, 1, 'h01, 0, 0);

    // BCD wraps, carry and borrow
    pulse(B_DOWN);  expect_st("month_down_wrap", 1, 4, 1, 'h12, 0, 0);
    push_wr(4, 'h12);
    pulse(B_LEFT); step(); ack(); step();
    expect_st("load3", 1, 3, 1, 'h09, 0, 0);
    pulse(B_UP);    expect_st("day_carry", 1, 3, 1, 'h10, 0, 0);
    pulse(B_DOWN);  expect_st("day_borrow", 1, 3, 1, 'h09, 0, 0);
    pulse(B_UP);
    push_wr(3, 'h10);
    pulse(B_RIGHT); step(); ack(); step();
    expect_st("load4b", 1, 4, 1, 'h01, 0, 0);
    pulse(B_RIGHT); step();
    expect_st("load5", 1, 5, 1, 'h99, 0, 0);
    pulse(B_UP);    expect_st("year_up_wrap", 1, 5, 1, 'h00, 0, 0);
    pulse(B_DOWN);  expect_st("year_down_wrap", 1, 5, 1, 'h99, 0, 0);
    pulse(B_UP);

    // ack timeout: req held 4 cycles, single error pulse, pending move still happens
    push_wr(5, 'h00);
    pulse(B_RIGHT);
    step(); expect_st("to_req0", 1, 5, -1, 'h00, 1, 0);
    repeat (3) begin step(); expect_st("to_req_hold", 1, 5, -1, 'h00, 1, 0); end
    step(); expect_st("timeout", 1, 6, -1, -1, 0, 1);
    step(); expect_st("err_single", 1, 6, 1, 'h12, 0, 0);

    // blink with FRAME_BLINK=2
    pulse(B_FRAME); expect_st("blink1", 1, 6, 1, -1, 0, 0);
    pulse(B_FRAME); expect_st("blink2", 1, 6, 0, -1, 0, 0);
    pulse(B_FRAME); expect_st("blink3", 1, 6, 0, -1, 0, 0);
    pulse(B_FRAME); expect_st("blink4", 1, 6, 1, -1, 0, 0);
    pulse(B_FRAME); expect_st("blink5", 1, 6, 1, -1, 0, 0);
    pulse(B_FRAME | B_UP); expect_st("blink_restart", 1, 6, 1, 'h13, 0, 0);
    pulse(B_FRAME); expect_st("blink_after_restart", 1, 6, 1, -1, 0, 0);
    pulse(B_FRAME); expect_st("blink_toggle_again", 1, 6, 0, -1, 0, 0);

    // alarm abort while dirty, prog ignored during alarm
    alarm_active = 1'b1;
    step();         expect_st("alarm_abort", 0, 15, 0, -1, 0, 0);
    pulse(B_PROG);  expect_st("prog_alarm_ignored", 0, 15, 0, -1, 0, 0);
    alarm_active = 1'b0;

    // prog beats up in the same cycle
    pulse(B_PROG); step();
    expect_st("load0b", 1, 0, 1, 'h23, 0, 0);
    pulse(B_PROG | B_UP); expect_st("prio_prog", 0, 15, 0, 'h23, 0, 0);

    // reset during WAIT_ACK
    pulse(B_PROG); step();
    pulse(B_UP);
    push_wr(0, 'h00);
    pulse(B_RIGHT);
    step();         expect_st("req_before_reset", 1, 0, -1, 'h00, 1, 0);
    reset = 1'b1;
    step();         expect_st("reset_mid_write", 0, 15, 0, 0, 0, 0);
    reset = 1'b0;
    step(2);
    chk("writes_all_seen", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
